alu_iterative: RTL and testbench

//  Execution-stage ALU, directly downstream of ALU_Control: consumes the 3-bit ALU

---
 rtl/alu_iterative.sv | 108 ++++++++++
 tb/tb_alu_iterative.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iterative.sv
// Execution-stage ALU: single-cycle AND/OR/ADD/SUB, iterative shift-add MUL.
// Registered outputs with a valid/ready handshake toward the issuing stage.
module alu_iterative #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic             valid_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] acc_next;

    // Single-cycle result; reserved codes (and MUL here) give zero
    always_comb begin
        alu_res = '0;
        case (ALUCtrl_i)
            3'd0:    alu_res = data1_i & data2_i;
            3'd1:    alu_res = data1_i | data2_i;
            3'd2:    alu_res = data1_i + data2_i;
            3'd3:    alu_res = data1_i - data2_i;
            default: alu_res = '0;
        endcase
    end

    // Partial-product step: add the shifted multiplicand when the multiplier LSB is set
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    // Control FSM and all output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
            data_o  <= '0;
            zero_o  <= 1'b1;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    valid_o <= 1'b0;
                    if (valid_i) begin
                        if (ALUCtrl_i == 3'd4) begin
                            mcand   <= data1_i;
                            mplier  <= data2_i;
                            acc     <= '0;
                            cnt     <= '0;
                            state   <= MUL;
                            ready_o <= 1'b0;
                        end else begin
                            data_o  <= alu_res;
                            zero_o  <= (alu_res == '0);
                            valid_o <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    valid_o <= 1'b0;
                    acc     <= acc_next;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    cnt     <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        data_o  <= acc_next;
                        zero_o  <= (acc_next == '0);
                        valid_o <= 1'b1;
                        state   <= IDLE;
                        ready_o <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_o <= 1'b1;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iterative.sv
// Bench for alu_iterative: edge-level behavioural model plus directed vectors.
// Every output is compared to the model after each clock edge.
module tb_alu_iterative;

    localparam int W = 32;

    logic         clk_i   = 1'b0;
    logic         rst_i   = 1'b1;
    logic         valid_i = 1'b0;
    logic [2:0]   ctrl    = 3'd0;
    logic [W-1:0] d1      = '0;
    logic [W-1:0] d2      = '0;
    logic         ready_o;
    logic         valid_o;
    logic         zero_o;
    logic [W-1:0] data_o;

    int errors = 0;
    int checks = 0;

    alu_iterative #(.WIDTH(W)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .ALUCtrl_i (ctrl),
        .data1_i   (d1),
        .data2_i   (d2),
        .data_o    (data_o),
        .zero_o    (zero_o),
        .valid_o   (valid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: what the outputs must be after each edge
    bit           m_busy  = 1'b0;
    int           m_left  = 0;
    logic [W-1:0] m_pend  = '0;
    logic [W-1:0] m_data  = '0;
    logic         m_zero  = 1'b1;
    logic         m_valid = 1'b0;
    logic         m_ready = 1'b1;

    function automatic logic [W-1:0] ref_op(input logic [2:0] c,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (c)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd3:    return a - b;
            default: return '0;
        endcase
    endfunction

    // Model: an accepted MUL produces a*b exactly W edges later
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_busy  = 1'b0;
            m_left  = 0;
            m_pend  = '0;
            m_data  = '0;
            m_zero  = 1'b1;
            m_valid = 1'b0;
            m_ready = 1'b1;
        end else begin
            m_valid = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_data  = m_pend;
                    m_zero  = (m_pend == '0);
                    m_valid = 1'b1;
                    m_busy  = 1'b0;
                end
            end else if (valid_i) begin
                if (ctrl == 3'd4) begin
                    m_pend = d1 * d2;
                    m_busy = 1'b1;
                    m_left = W;
                end else begin
                    m_data  = ref_op(ctrl, d1, d2);
                    m_zero  = (m_data == '0);
                    m_valid = 1'b1;
                end
            end
            m_ready = !m_busy;
        end
    end

    // Compare every output against the model after each edge
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            chk("cmp_ready", W'(ready_o), W'(m_ready));
            chk("cmp_valid", W'(valid_o), W'(m_valid));
            chk("cmp_zero",  W'(zero_o),  W'(m_zero));
            chk("cmp_data",  data_o,      m_data);
        end
    end

    // Present a request and return at the edge where it is accepted
    task automatic issue(input logic [2:0] c, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        logic r;
        bit   done;
        @(negedge clk_i);
        valid_i = 1'b1;
        ctrl    = c;
        d1      = a;
        d2      = b;
        done    = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            r = ready_o;
            @(posedge clk_i);
            if (r) done = 1'b1;
        end
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    task automatic drop();
        @(negedge clk_i);
        valid_i = 1'b0;
    endtask

    // Count edges until valid_o, and how many of them saw ready_o low
    task automatic wait_valid(output int n, inout int lows);
        n = 61;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk_i);
            #1;
            if (!ready_o) lows++;
            if (valid_o) begin
                n = i;
                break;
            end
        end
    endtask

    int n;
    int lows;
    int pulses;

    initial begin
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("rst_ready", W'(ready_o), 1);
        chk("rst_valid", W'(valid_o), 0);
        chk("rst_data",  data_o, 0);
        chk("rst_zero",  W'(zero_o), 1);

        issue(3'd0, 32'hF0F0F0F0, 32'h0FF00FF0);
        #1;
        chk("and_data",  data_o, 32'h00F000F0);
        chk("and_valid", W'(valid_o), 1);
        issue(3'd1, 32'hF0F0F0F0, 32'h0FF00FF0);
        #1;
        chk("or_data",  data_o, 32'hFFF0FFF0);
        chk("or_valid", W'(valid_o), 1);
        drop();
        @(posedge clk_i);
        #1;
        chk("idle_valid", W'(valid_o), 0);
        chk("idle_hold",  data_o, 32'hFFF0FFF0);

        issue(3'd2, 32'hFFFFFFFF, 32'h1);
        #1;
        chk("add_wrap", data_o, 0);
        chk("add_zero", W'(zero_o), 1);
        issue(3'd3, 32'd5, 32'd7);
        #1;
        chk("sub_data", data_o, 32'hFFFFFFFE);
        chk("sub_zero", W'(zero_o), 0);
        drop();

        issue(3'd4, 32'd7, 32'd6);
        #1;
        valid_i = 1'b0;
        lows = ready_o ? 0 : 1;
        wait_valid(n, lows);
        chk("mul_lat",   n, 32);
        chk("mul_lows",  lows, 32);
        chk("mul_data",  data_o, 32'd42);
        chk("mul_ready", W'(ready_o), 1);

        issue(3'd4, 32'hFFFFFFFF, 32'd2);
        #1;
        valid_i = 1'b0;
        lows = 0;
        wait_valid(n, lows);
        chk("mul2_lat",  n, 32);
        chk("mul2_data", data_o, 32'hFFFFFFFE);

        for (int i = 1; i <= 4; i++) begin
            issue(3'd2, W'(i), W'(i));
            #1;
            chk("b2b_data",  data_o, W'(2 * i));
            chk("b2b_valid", W'(valid_o), 1);
        end
        drop();
        @(posedge clk_i);
        #1;
        chk("b2b_end", W'(valid_o), 0);

        issue(3'd6, 32'd1, 32'd1);
        #1;
        chk("rsv_data",  data_o, 0);
        chk("rsv_zero",  W'(zero_o), 1);
        chk("rsv_valid", W'(valid_o), 1);
        drop();

        issue(3'd4, 32'd3, 32'd3);
        #1;
        ctrl = 3'd2;
        d1   = 32'd9;
        d2   = 32'd9;
        lows = 0;
        wait_valid(n, lows);
        chk("stall_lat",  n, 32);
        chk("stall_mul",  data_o, 32'd9);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        chk("stall_add",  data_o, 32'd18);
        chk("stall_addv", W'(valid_o), 1);

        issue(3'd4, 32'd100, 32'd100);
        #1;
        valid_i = 1'b0;
        repeat (9) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("abort_ready", W'(ready_o), 1);
        chk("abort_data",  data_o, 0);
        chk("abort_valid", W'(valid_o), 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i);
            #1;
            if (valid_o) pulses++;
        end
        chk("abort_pulses", pulses, 0);
        chk("abort_hold",   data_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
